// File: rtl/rlight_tlul.sv
// Running-light (LED chaser) peripheral on a TL-UL device port.
// Optional status register at 0x8 enabled by defining RLIGHT_STATUS_EN.

package tlul_pkg;
    localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] GET              = 3'd4;
    localparam logic [2:0] ACCESS_ACK       = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA  = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module rlight_tlul #(
    parameter logic [31:0] RESET_PATTERN = 32'h0000_0001,
    parameter logic [31:0] RESET_CTRL    = 32'h17D7_8401
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  tlul_pkg::tl_h2d_t  tl_i,
    output tlul_pkg::tl_d2h_t  tl_o,
    output logic [7:0]         led_o
);
    import tlul_pkg::*;

    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [7:0]  led;
    logic [23:0] cnt;
    logic        dir;

    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;

    logic        accept;
    logic        is_get;
    logic        is_put;
    logic        sel_a;
    logic        sel_b;
    logic        sel_s;
    logic        err;
    logic        wr_a;
    logic        wr_b;
    logic [31:0] bit_mask;
    logic [31:0] wdata_a;
    logic [31:0] wdata_b;
    logic [31:0] rdata;
    logic [23:0] pre;
    logic [1:0]  mode;
    logic [7:0]  led_step;
    logic        dir_step;
    logic        unused_tl;

    assign unused_tl = ^{tl_i.a_param, tl_i.a_user};

    assign accept = tl_i.a_valid && !d_valid;
    assign is_get = (tl_i.a_opcode == GET);
    assign is_put = (tl_i.a_opcode == PUT_FULL_DATA) || (tl_i.a_opcode == PUT_PARTIAL_DATA);
    assign sel_a  = (tl_i.a_address[31:2] == 30'd0);
    assign sel_b  = (tl_i.a_address[31:2] == 30'd1);
`ifdef RLIGHT_STATUS_EN
    assign sel_s  = (tl_i.a_address[31:2] == 30'd2);
`else
    assign sel_s  = 1'b0;
`endif

    // Status register is read-only, so a Put to it is an error.
    assign err  = !(is_get || is_put) || !(sel_a || sel_b || sel_s) || (is_put && sel_s);
    assign wr_a = accept && is_put && sel_a;
    assign wr_b = accept && is_put && sel_b;

    assign bit_mask = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                       {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};
    assign wdata_a  = (reg_a & ~bit_mask) | (tl_i.a_data & bit_mask);
    assign wdata_b  = ((reg_b & ~bit_mask) | (tl_i.a_data & bit_mask)) & 32'hFFFF_FF03;

    always_comb begin
        rdata = 32'd0;
        if (is_get && !err) begin
            if (sel_a)
                rdata = reg_a;
            else if (sel_b)
                rdata = reg_b;
            else
                rdata = {23'd0, dir, led};
        end
    end

    assign pre  = reg_b[31:8];
    assign mode = reg_b[1:0];

    always_comb begin
        led_step = led;
        dir_step = dir;
        case (mode)
            2'd1: led_step = {led[6:0], led[7]};
            2'd2: led_step = {led[0], led[7:1]};
            2'd3: begin
                if (!dir) begin
                    if (led[7]) begin
                        dir_step = 1'b1;
                        led_step = {1'b0, led[7:1]};
                    end else begin
                        led_step = {led[6:0], 1'b0};
                    end
                end else begin
                    if (led[0]) begin
                        dir_step = 1'b0;
                        led_step = {led[6:0], 1'b0};
                    end else begin
                        led_step = {1'b0, led[7:1]};
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_a    <= RESET_PATTERN;
            reg_b    <= RESET_CTRL & 32'hFFFF_FF03;
            led      <= RESET_PATTERN[7:0];
            cnt      <= RESET_CTRL[31:8];
            dir      <= 1'b0;
            d_valid  <= 1'b0;
            d_opcode <= ACCESS_ACK;
            d_size   <= 2'd0;
            d_source <= 8'd0;
            d_data   <= 32'd0;
            d_error  <= 1'b0;
        end else begin
            if (wr_a)
                reg_a <= wdata_a;
            if (wr_b)
                reg_b <= wdata_b;

            // Register writes win over a pending step.
            if (wr_a) begin
                led <= wdata_a[7:0];
                cnt <= pre;
                dir <= 1'b0;
            end else if (wr_b) begin
                cnt <= wdata_b[31:8];
            end else if (mode != 2'd0) begin
                if (cnt == 24'd0) begin
                    led <= led_step;
                    dir <= dir_step;
                    cnt <= pre;
                end else begin
                    cnt <= cnt - 24'd1;
                end
            end

            if (accept) begin
                d_valid  <= 1'b1;
                d_opcode <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
                d_size   <= tl_i.a_size;
                d_source <= tl_i.a_source;
                d_data   <= rdata;
                d_error  <= err;
            end else if (d_valid && tl_i.d_ready) begin
                d_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = d_valid;
        tl_o.d_opcode = d_opcode;
        tl_o.d_size   = d_size;
        tl_o.d_source = d_source;
        tl_o.d_data   = d_data;
        tl_o.d_error  = d_error;
        tl_o.a_ready  = !d_valid;
    end

    assign led_o = led;
endmodule

// File: tb/tb_rlight_tlul.sv
// Self-checking bench for rlight_tlul: directed steps plus a randomized phase
// checked every cycle against a behavioural model of registers and light engine.

module tb_rlight_tlul;
    import tlul_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    tl_h2d_t    tl_i;
    tl_d2h_t    tl_o;
    logic [7:0] led_o;

    int n_tests = 0;
    int n_fail  = 0;

    rlight_tlul dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .tl_i  (tl_i),
        .tl_o  (tl_o),
        .led_o (led_o)
    );

    always #5 clk_i = ~clk_i;

    // model state
    logic [31:0] m_a, m_b;
    logic [7:0]  m_led;
    logic [23:0] m_cnt;
    logic        m_dir;
    logic        m_dv, m_derr;
    logic [2:0]  m_dop;
    logic [1:0]  m_dsize;
    logic [7:0]  m_dsrc;
    logic [31:0] m_ddata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 32'h0000_0001;
        m_b = 32'h17D7_8401;
        m_led = 8'h01;
        m_cnt = 24'h17D784;
        m_dir = 1'b0;
        m_dv = 1'b0;
        m_derr = 1'b0;
        m_dop = 3'd0;
        m_dsize = 2'd0;
        m_dsrc = 8'd0;
        m_ddata = 32'd0;
    endtask

    // One light-engine step expressed as plain arithmetic on the pattern value.
    task automatic model_step(output logic [7:0] nl, output logic nd);
        int li;
        li = int'(m_led);
        nl = m_led;
        nd = m_dir;
        case (m_b[1:0])
            2'd1: nl = 8'((li * 2) % 256 + li / 128);
            2'd2: nl = 8'(li / 2 + (li % 2) * 128);
            2'd3: begin
                if (!m_dir) begin
                    if (li >= 128) begin nd = 1'b1; nl = 8'(li / 2); end
                    else nl = 8'((li * 2) % 256);
                end else begin
                    if (li % 2 == 1) begin nd = 1'b0; nl = 8'((li * 2) % 256); end
                    else nl = 8'(li / 2);
                end
            end
            default: ;
        endcase
    endtask

    // Advance one clock: predict from currently driven inputs, then compare.
    task automatic cycle();
        logic        acc, is_get, is_put, sa, sb, ss, err;
        logic [31:0] bm, wv, rd, n_a, n_b;
        logic [7:0]  n_led, s_led;
        logic [23:0] n_cnt;
        logic        n_dir, s_dir;
        int          word;

        acc    = tl_i.a_valid && !m_dv;
        is_get = (tl_i.a_opcode == 3'd4);
        is_put = (tl_i.a_opcode == 3'd0) || (tl_i.a_opcode == 3'd1);
        word   = (tl_i.a_address >= 32'h0000_0100) ? 999 : int'(tl_i.a_address / 4);
        sa = (word == 0);
        sb = (word == 1);
`ifdef RLIGHT_STATUS_EN
        ss = (word == 2);
`else
        ss = 1'b0;
`endif
        err = !(is_get || is_put) || !(sa || sb || ss) || (is_put && ss);
        bm = 32'd0;
        for (int b = 0; b < 4; b++)
            if (tl_i.a_mask[b]) bm[8*b +: 8] = 8'hFF;

        rd = 32'd0;
        if (is_get && !err)
            rd = sa ? m_a : (sb ? m_b : {23'd0, m_dir, m_led});

        n_a = m_a; n_b = m_b; n_led = m_led; n_cnt = m_cnt; n_dir = m_dir;
        if (acc && is_put && sa) begin
            wv = (m_a & ~bm) | (tl_i.a_data & bm);
            n_a = wv; n_led = wv[7:0]; n_cnt = m_b[31:8]; n_dir = 1'b0;
        end else if (acc && is_put && sb) begin
            wv = ((m_b & ~bm) | (tl_i.a_data & bm)) & 32'hFFFF_FF03;
            n_b = wv; n_cnt = wv[31:8];
        end else if (m_b[1:0] != 2'd0) begin
            if (m_cnt == 24'd0) begin
                model_step(s_led, s_dir);
                n_led = s_led; n_dir = s_dir; n_cnt = m_b[31:8];
            end else begin
                n_cnt = m_cnt - 24'd1;
            end
        end

        @(posedge clk_i);
        #1;
        m_a = n_a; m_b = n_b; m_led = n_led; m_cnt = n_cnt; m_dir = n_dir;
        if (acc) begin
            m_dv = 1'b1;
            m_dop = is_get ? 3'd1 : 3'd0;
            m_dsize = tl_i.a_size;
            m_dsrc = tl_i.a_source;
            m_ddata = rd;
            m_derr = err;
        end else if (m_dv && tl_i.d_ready) begin
            m_dv = 1'b0;
        end

        check("led", 32'(led_o), 32'(m_led));
        check("d_valid", 32'(tl_o.d_valid), 32'(m_dv));
        check("a_ready", 32'(tl_o.a_ready), 32'(!m_dv));
        if (m_dv) begin
            check("d_data", tl_o.d_data, m_ddata);
            check("d_error", 32'(tl_o.d_error), 32'(m_derr));
            check("d_opcode", 32'(tl_o.d_opcode), 32'(m_dop));
            check("d_source", 32'(tl_o.d_source), 32'(m_dsrc));
            check("d_size", 32'(tl_o.d_size), 32'(m_dsize));
            check("d_param_sink_user", 32'({tl_o.d_param, tl_o.d_sink, tl_o.d_user}), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input int hold,
                       output logic [31:0] rdata, output logic rerr);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_address = addr;
        tl_i.a_data    = data;
        tl_i.a_mask    = mask;
        tl_i.a_size    = 2'($urandom);
        tl_i.a_source  = 8'($urandom);
        tl_i.d_ready   = (hold == 0);
        cycle();
        tl_i.a_valid = 1'b0;
        rdata = tl_o.d_data;
        rerr  = tl_o.d_error;
        for (int i = 0; i < hold; i++) cycle();
        tl_i.d_ready = 1'b1;
        cycle();
    endtask

    logic [31:0] rd;
    logic        er;
    logic [7:0]  bounce [15];

    initial begin
        bounce = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20,
                   8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        rst_i = 1'b1;
        tl_i = '0;
        tl_i.d_ready = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();

        check("reset_led", 32'(led_o), 32'h01);
        check("reset_d_valid", 32'(tl_o.d_valid), 32'd0);
        check("reset_a_ready", 32'(tl_o.a_ready), 32'd1);

        txn(GET, 32'h0, 32'h0, 4'hF, 0, rd, er);
        check("get_a_reset", rd, 32'h0000_0001);

        txn(PUT_FULL_DATA, 32'h0, 32'h1234_5678, 4'hF, 0, rd, er);
        check("led_after_put_a", 32'(led_o), 32'h78);
        txn(GET, 32'h0, 32'h0, 4'hF, 0, rd, er);
        check("get_a_written", rd, 32'h1234_5678);

        txn(PUT_FULL_DATA, 32'h4, 32'hFFFF_FF01, 4'hF, 0, rd, er);
        txn(GET, 32'h4, 32'h0, 4'hF, 0, rd, er);
        check("get_b_written", rd, 32'hFFFF_FF01);

        txn(PUT_FULL_DATA, 32'h4, 32'h0000_0001, 4'hF, 0, rd, er);
        check("rotl_first", 32'(led_o), 32'hF0);
        cycle();
        check("rotl_second", 32'(led_o), 32'hE1);

        txn(PUT_FULL_DATA, 32'h4, 32'h0000_0002, 4'hF, 0, rd, er);
        txn(PUT_FULL_DATA, 32'h0, 32'h0000_0001, 4'hF, 0, rd, er);
        check("rotr_first", 32'(led_o), 32'h80);
        cycle();
        check("rotr_second", 32'(led_o), 32'h40);

        txn(PUT_FULL_DATA, 32'h4, 32'h0000_0000, 4'hF, 0, rd, er);
        idle(6);

        txn(PUT_FULL_DATA, 32'h4, 32'h0000_0003, 4'hF, 0, rd, er);
        txn(PUT_FULL_DATA, 32'h0, 32'h0000_0001, 4'hF, 0, rd, er);
        check("pingpong_start", 32'(led_o), 32'h02);
        for (int i = 0; i < 15; i++) begin
            cycle();
            check("pingpong_seq", 32'(led_o), 32'(bounce[i]));
        end

        txn(PUT_FULL_DATA, 32'h4, 32'hFFFF_FF01, 4'hF, 0, rd, er);
        txn(PUT_PARTIAL_DATA, 32'h4, 32'h0000_0003, 4'b0001, 0, rd, er);
        txn(GET, 32'h4, 32'h0, 4'hF, 0, rd, er);
        check("partial_b", rd, 32'hFFFF_FF03);

        txn(GET, 32'h10, 32'h0, 4'hF, 0, rd, er);
        check("unmapped_err", 32'(er), 32'd1);
        check("unmapped_data", rd, 32'd0);

        txn(3'd2, 32'h0, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
        check("bad_opcode_err", 32'(er), 32'd1);
        txn(PUT_FULL_DATA, 32'h8, 32'h0000_00FF, 4'hF, 0, rd, er);
        check("put_status_err", 32'(er), 32'd1);
        txn(GET, 32'h8, 32'h0, 4'hF, 0, rd, er);
        txn(GET, 32'h0, 32'h0, 4'hF, 2, rd, er);

        for (int it = 0; it < 40; it++) begin
            logic [31:0] addr, data;
            logic [2:0]  op;
            int          sel;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: begin op = PUT_FULL_DATA; addr = 32'h0; end
                1: begin op = PUT_PARTIAL_DATA; addr = 32'h4; end
                2: begin op = GET; addr = 32'h0; end
                3: begin op = GET; addr = 32'h4; end
                4: begin op = GET; addr = 32'h8; end
                default: begin op = 3'($urandom); addr = 32'($urandom_range(0, 15)) * 4; end
            endcase
            data = $urandom;
            if (addr == 32'h4)
                data[31:8] = 24'($urandom_range(0, 3));
            txn(op, addr, data, 4'($urandom), int'($urandom_range(0, 2)), rd, er);
            idle(int'($urandom_range(0, 5)));
        end

        txn(PUT_FULL_DATA, 32'h0, 32'h0000_0055, 4'hF, 0, rd, er);
        tl_i.a_valid = 1'b1; tl_i.a_opcode = GET; tl_i.a_address = 32'h0;
        tl_i.a_mask = 4'hF; tl_i.a_size = 2'd2; tl_i.a_source = 8'h5A; tl_i.d_ready = 1'b0;
        cycle();
        tl_i.a_valid = 1'b0;
        rd = tl_o.d_data;
        check("bp_data_first", rd, m_a);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_data_stable", tl_o.d_data, rd);
            check("bp_a_ready_low", 32'(tl_o.a_ready), 32'd0);
        end
        tl_i.d_ready = 1'b1;
        cycle();

        txn(PUT_FULL_DATA, 32'h0, 32'h0000_00A5, 4'hF, 0, rd, er);
        tl_i.a_valid = 1'b1; tl_i.a_opcode = GET; tl_i.a_address = 32'h4;
        tl_i.a_mask = 4'hF; tl_i.d_ready = 1'b0;
        cycle();
        tl_i.a_valid = 1'b0;
        cycle();
        rst_i = 1'b1;
        #2;
        check("rst_mid_d_valid", 32'(tl_o.d_valid), 32'd0);
        check("rst_mid_led", 32'(led_o), 32'h01);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        tl_i.d_ready = 1'b1;
        model_reset();
        txn(GET, 32'h4, 32'h0, 4'hF, 0, rd, er);
        check("rst_mid_reg_b", rd, 32'h17D7_8401);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout: observed running expected finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end
endmodule
